// File: rtl/mod_addsub_pkg.sv
// Shared types and constants for the modular add/sub scheduler.
// State encoding, op encoding, default width/modulus and the id-width helper.
package mod_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int DEF_W = 4;
   localparam int DEF_M = (1 << DEF_W) - 1;
   localparam int CNT_W = 3;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mod_addsub_sched_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter
   import mod_addsub_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   int pos;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = 0;
      for (int k = 0; k < NREQ; k++) begin
         pos = (int'(ptr) + k) % NREQ;
         if (!any && req[pos]) begin
            gnt[pos] = 1'b1;
            idx      = IDW'(pos);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mod_addsub_sched.sv
// Shares one mod (2^W-1) add/sub datapath among NREQ requesters; grant to rsp_valid is DP_LAT+1 cycles.
// Requests are only accepted in IDLE; response held until rsp_ready. Option: MOD_ADDSUB_SCHED_RANGECHK_EN adds rsp_err.
module mod_addsub_sched
   import mod_addsub_pkg::*;
#(
   parameter  int NREQ   = 4,
   parameter  int W      = 4,
   parameter  int DP_LAT = 1,
   localparam int IDW    = id_width(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_op,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_data,
   output logic [W-1:0]      dp_a,
   output logic [W-1:0]      dp_b,
   output logic              dp_s,
   input  logic [W-1:0]      dp_res,
`ifdef MOD_ADDSUB_SCHED_RANGECHK_EN
   output logic              rsp_err,
`endif
   output logic              busy
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [IDW-1:0]     rr_ptr;
   logic [NREQ-1:0]    gnt;
   logic [IDW-1:0]     gnt_idx;
   logic               gnt_any;
   logic [W-1:0]       win_a, win_b;
   logic               win_op;
   logic               launch, capture, rsp_fire;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   assign win_a  = req_a[int'(gnt_idx)*W +: W];
   assign win_b  = req_b[int'(gnt_idx)*W +: W];
   assign win_op = req_op[gnt_idx];
   assign busy   = (state != IDLE);

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      launch    = 1'b0;
      capture   = 1'b0;
      rsp_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_any) begin
               req_ready = gnt;
               launch    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_fire  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // dp_* are only reloaded on a grant, so dp_res is stable while it settles and is captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rr_ptr    <= '0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
         dp_a      <= '0;
         dp_b      <= '0;
         dp_s      <= OP_ADD;
      end else begin
         state <= state_nxt;
         if (launch) begin
            dp_a   <= win_a;
            dp_b   <= win_b;
            dp_s   <= win_op;
            rsp_id <= gnt_idx;
            cnt    <= CNT_W'(DP_LAT);
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (capture) begin
            rsp_data  <= dp_res;
            rsp_valid <= 1'b1;
         end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
         end
         if (rsp_fire) begin
            rr_ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
         end
      end
   end

`ifdef MOD_ADDSUB_SCHED_RANGECHK_EN
   // All-ones is the alternate encoding of zero; flag it as out of range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err <= 1'b0;
      end else if (launch) begin
         rsp_err <= (win_a == '1) || (win_b == '1);
      end
   end
`endif

endmodule

// File: tb/tb_mod_addsub_sched.sv
// Directed bench for mod_addsub_sched: reset, add/sub wrap, backpressure, round-robin order, DP_LAT=3 latency.
module tb_mod_addsub_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;

   logic [3:0]  req_valid, req_op, req_ready;
   logic [15:0] req_a, req_b;
   logic        rsp_valid, rsp_ready, dp_s, busy;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_data, dp_a, dp_b, dp_res;

   logic [3:0]  req_valid3, req_op3, req_ready3;
   logic [15:0] req_a3, req_b3;
   logic        rsp_valid3, rsp_ready3, dp_s3, busy3;
   logic [1:0]  rsp_id3;
   logic [3:0]  rsp_data3, dp_a3, dp_b3, dp_res3;
`ifdef MOD_ADDSUB_SCHED_RANGECHK_EN
   logic        rsp_err, rsp_err3;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Reference datapath: (a op b) mod 15.
   function automatic logic [3:0] dp_model(input logic [3:0] a, input logic [3:0] b, input logic s);
      int t;
      t = s ? (int'(a) - int'(b) + 15) : (int'(a) + int'(b));
      return 4'(t % 15);
   endfunction

   assign dp_res  = dp_model(dp_a, dp_b, dp_s);
   assign dp_res3 = dp_model(dp_a3, dp_b3, dp_s3);

   mod_addsub_sched #(.NREQ(4), .W(4), .DP_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .dp_a(dp_a), .dp_b(dp_b), .dp_s(dp_s), .dp_res(dp_res),
`ifdef MOD_ADDSUB_SCHED_RANGECHK_EN
      .rsp_err(rsp_err),
`endif
      .busy(busy)
   );

   mod_addsub_sched #(.NREQ(4), .W(4), .DP_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
      .req_a(req_a3), .req_b(req_b3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
      .dp_a(dp_a3), .dp_b(dp_b3), .dp_s(dp_s3), .dp_res(dp_res3),
`ifdef MOD_ADDSUB_SCHED_RANGECHK_EN
      .rsp_err(rsp_err3),
`endif
      .busy(busy3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int exp_ord [5] = '{0, 1, 2, 3, 0};
   logic [3:0] exp_res [4] = '{4'd8, 4'd10, 4'd2, 4'd0};
   int ngnt, last_hs, lat;

   initial begin
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      req_valid3 = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0;

      // Reset state
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_dp_a", dp_a, 0);
      check("rst_dp_b", dp_b, 0);
      check("rst_dp_s", dp_s, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single add on requester 0: 9+8 mod 15 = 2
      @(negedge clk);
      req_a[3:0] = 4'd9; req_b[3:0] = 4'd8; req_op[0] = 1'b0; req_valid = 4'b0001;
      #1;
      check("add_ready", req_ready, 4'b0001);
      check("add_idle_busy", busy, 0);
      @(negedge clk);
      check("add_wait_ready", req_ready, 0);
      check("add_wait_busy", busy, 1);
      check("add_dp_a", dp_a, 9);
      check("add_dp_b", dp_b, 8);
      check("add_dp_s", dp_s, 0);
      check("add_wait_valid", rsp_valid, 0);
      req_valid = '0;
      @(negedge clk);
      check("add_rsp_valid", rsp_valid, 1);
      check("add_rsp_id", rsp_id, 0);
      check("add_rsp_data", rsp_data, 2);

      // Backpressure with every requester pending
      req_valid = 4'hf; rsp_ready = 1'b0;
      #1;
      check("bp_ready0", req_ready, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", rsp_valid, 1);
         check("bp_data", rsp_data, 2);
         check("bp_id", rsp_id, 0);
         check("bp_ready", req_ready, 0);
         check("bp_busy", busy, 1);
      end
      rsp_ready = 1'b1; req_valid = '0;
      @(negedge clk);
      check("bp_release_valid", rsp_valid, 0);
      check("bp_release_busy", busy, 0);
      rsp_ready = 1'b0;

      // Subtract wrap on requester 2: 3-5 mod 15 = 13
      req_a[11:8] = 4'd3; req_b[11:8] = 4'd5; req_op[2] = 1'b1; req_valid = 4'b0100;
      #1;
      check("sub_ready", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = '0;
      for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
      check("sub_valid", rsp_valid, 1);
      check("sub_id", rsp_id, 2);
      check("sub_data", rsp_data, 13);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("sub_done_valid", rsp_valid, 0);

      // Reset while in WAIT on requester 1
      req_a[7:4] = 4'd5; req_b[7:4] = 4'd5; req_op[1] = 1'b0; req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      check("mid_busy", busy, 1);
      check("mid_id", rsp_id, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_id", rsp_id, 0);
      check("mid_rst_dp_a", dp_a, 0);
      check("mid_rst_dp_b", dp_b, 0);
      check("mid_rst_valid", rsp_valid, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mid_no_stale", rsp_valid, 0);
      end

      // Round-robin with all requesters held valid and rsp_ready tied high
      req_a = {4'd4, 4'd3, 4'd2, 4'd1};
      req_b = {4'd4, 4'd14, 4'd7, 4'd7};
      req_op = 4'b1010;
      req_valid = 4'hf; rsp_ready = 1'b1;
      ngnt = 0; last_hs = -100;
      #1;
      for (int cyc = 0; cyc < 40 && ngnt < 5; cyc++) begin
         if (rsp_valid) begin
            check("rr_data", rsp_data, exp_res[rsp_id]);
            last_hs = cyc;
         end
         if (req_ready != 0) begin
            check("rr_order", req_ready, 4'b0001 << exp_ord[ngnt]);
            if (ngnt > 0) check("rr_gap", cyc - last_hs, 1);
            ngnt++;
         end
         if (ngnt < 5) begin
            @(negedge clk);
            #1;
         end
      end
      check("rr_count", ngnt, 5);
      // Withdrawn before the edge: the fifth grant must not launch
      req_valid = '0; rsp_ready = 1'b0;
      @(negedge clk);
      check("withdraw_busy", busy, 0);
      @(negedge clk);
      check("withdraw_valid", rsp_valid, 0);

      // DP_LAT=3: 15+1 mod 15 = 1, out-of-range operand
      req_a3[3:0] = 4'd15; req_b3[3:0] = 4'd1; req_op3[0] = 1'b0; req_valid3 = 4'b0001;
      #1;
      check("l3_ready", req_ready3, 4'b0001);
      @(negedge clk);
      req_valid3 = '0;
      lat = 1;
      while (!rsp_valid3 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("l3_lat_a", lat, 4);
      check("l3_data_a", rsp_data3, 1);
`ifdef MOD_ADDSUB_SCHED_RANGECHK_EN
      check("l3_err_a", rsp_err3, 1);
`endif
      rsp_ready3 = 1'b1;
      @(negedge clk);
      rsp_ready3 = 1'b0;
      check("l3_done_a", rsp_valid3, 0);

      // DP_LAT=3: 14+1 mod 15 = 0, in range
      req_a3[3:0] = 4'd14; req_b3[3:0] = 4'd1; req_valid3 = 4'b0001;
      #1;
      check("l3_ready_b", req_ready3, 4'b0001);
      @(negedge clk);
      req_valid3 = '0;
      lat = 1;
      while (!rsp_valid3 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("l3_lat_b", lat, 4);
      check("l3_data_b", rsp_data3, 0);
`ifdef MOD_ADDSUB_SCHED_RANGECHK_EN
      check("l3_err_b", rsp_err3, 0);
`endif
      rsp_ready3 = 1'b1;
      @(negedge clk);
      rsp_ready3 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
